// File: rtl/fetch_pkg.sv
// Shared definitions for the Fetch-stage PC sequencer.
//   fetch_state_t : sequencer states (request outstanding / instruction held / wrong-path drain)
//   RESET_VEC_DEFAULT, NOP, PC_INC : fetch constants
//   align_word()  : clears the byte-offset bits of an address
package fetch_pkg;

    typedef enum logic [1:0] {
        StFetch = 2'd0,  // request outstanding for pcF
        StHold  = 2'd1,  // instruction captured, Decode stalled
        StDrain = 2'd2   // wrong-path request outstanding, its data will be dropped
    } fetch_state_t;

    localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0040_0030;
    localparam logic [31:0] NOP               = 32'h0000_0000;
    localparam logic [31:0] PC_INC            = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating wait counter for the instruction-memory handshake.
//   CLK      : clock, all updates on posedge
//   clear    : synchronous clear (reset or ack); wins over count_en
//   count_en : count one more cycle without an ack
//   expired  : count has reached MAX_WAIT (stays there until cleared)
module fetch_wait_timer #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic CLK,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        count_q <= count_d;
    end

    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: chooses the next PC and StallF for the PC register and runs one
// instruction-memory request per PC over a variable-latency req/ack handshake. Branch/jump
// redirects from Decode flush the Fetch/Decode register and discard wrong-path fetches.
//   CLK, RST            : clock, synchronous active-high reset
//   pcF                 : current PC from the PC register
//   StallD              : Decode stalled, Fetch must not advance
//   BranchTakenD/Target : taken branch and its target (wins over a simultaneous jump)
//   JumpD/JumpTargetD   : jump and its target
//   imem_req/addr       : instruction request, address is always pcF
//   imem_ack/rdata      : one-cycle response pulse and fetched word
//   pc, StallF          : next-PC value and hold for the PC register
//   InstrF, InstrValidF : instruction to the Fetch/Decode register and its valid
//   FlushD              : one-cycle clear of the Fetch/Decode register
//   misalign, fetch_err : sticky error flags (misaligned redirect, request timeout)
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEFAULT,
    parameter int unsigned MAX_WAIT  = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pcF,
    input  logic        StallD,
    input  logic        BranchTakenD,
    input  logic [31:0] BranchTargetD,
    input  logic        JumpD,
    input  logic [31:0] JumpTargetD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        StallF,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        FlushD,
    output logic        misalign,
    output logic        fetch_err
);

    fetch_state_t state_q, state_d;

    logic [31:0] instr_q, instr_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        misalign_q, misalign_d;
    logic        err_q, err_d;

    logic        redirect;
    logic [31:0] target_raw;
    logic [31:0] target;
    logic        wait_clear;
    logic        wait_count;
    logic        wait_expired;

    assign redirect   = BranchTakenD | JumpD;
    assign target_raw = BranchTakenD ? BranchTargetD : JumpTargetD;
    assign target     = align_word(target_raw);
    assign imem_addr  = pcF;

    // Timer runs only while a request is waiting; any ack restarts it.
    assign wait_clear = RST | imem_ack;
    assign wait_count = imem_req & ~imem_ack;

    fetch_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .CLK      (CLK),
        .clear    (wait_clear),
        .count_en (wait_count),
        .expired  (wait_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (redirect) begin
                    // Without the ack the wrong-path request must still be drained.
                    state_d = imem_ack ? StFetch : StDrain;
                end else if (imem_ack) begin
                    state_d = StallD ? StHold : StFetch;
                end
            end
            StHold: begin
                if (redirect || !StallD) begin
                    state_d = StFetch;
                end
            end
            StDrain: begin
                if (imem_ack) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    // Datapath registers and sticky flags
    always_comb begin
        instr_d       = instr_q;
        redirect_pc_d = redirect_pc_q;
        misalign_d    = misalign_q;
        err_d         = err_q | wait_expired;
        if ((state_q == StFetch) && imem_ack && !redirect) begin
            instr_d = imem_rdata;
        end
        if (redirect) begin
            // Only consumed in StDrain; a later redirect simply replaces it.
            redirect_pc_d = target;
            misalign_d    = misalign_q | (target_raw[1:0] != 2'b00);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            instr_q       <= NOP;
            redirect_pc_q <= '0;
            misalign_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            redirect_pc_q <= redirect_pc_d;
            misalign_q    <= misalign_d;
            err_q         <= err_d;
        end
    end

    // Output logic
    always_comb begin
        imem_req    = 1'b0;
        pc          = pcF;
        StallF      = 1'b1;
        InstrF      = instr_q;
        InstrValidF = 1'b0;
        FlushD      = 1'b0;
        if (RST) begin
            pc     = RESET_VEC;
            InstrF = NOP;
        end else begin
            unique case (state_q)
                StFetch: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        FlushD = 1'b1;
                        if (imem_ack) begin
                            StallF = 1'b0;
                            pc     = target;
                        end
                    end else if (imem_ack) begin
                        // Fresh word goes straight through; instr_q keeps it for HOLD.
                        InstrF      = imem_rdata;
                        InstrValidF = 1'b1;
                        if (!StallD) begin
                            StallF = 1'b0;
                            pc     = pcF + PC_INC;
                        end
                    end
                end
                StHold: begin
                    InstrValidF = 1'b1;
                    if (redirect) begin
                        FlushD      = 1'b1;
                        InstrValidF = 1'b0;
                        StallF      = 1'b0;
                        pc          = target;
                    end else if (!StallD) begin
                        StallF = 1'b0;
                        pc     = pcF + PC_INC;
                    end
                end
                StDrain: begin
                    imem_req = 1'b1;
                    if (redirect) begin
                        FlushD = 1'b1;
                    end
                    if (imem_ack) begin
                        StallF = 1'b0;
                        pc     = redirect ? target : redirect_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign misalign  = ~RST & misalign_q;
    assign fetch_err = ~RST & (err_q | wait_expired);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0040_0030;
    localparam int          MW = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] pcF;
    logic        StallD;
    logic        BranchTakenD;
    logic [31:0] BranchTargetD;
    logic        JumpD;
    logic [31:0] JumpTargetD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic        StallF;
    logic [31:0] InstrF;
    logic        InstrValidF;
    logic        FlushD;
    logic        misalign;
    logic        fetch_err;

    pc_fetch_ctrl #(
        .RESET_VEC (RV),
        .MAX_WAIT  (MW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .pcF           (pcF),
        .StallD        (StallD),
        .BranchTakenD  (BranchTakenD),
        .BranchTargetD (BranchTargetD),
        .JumpD         (JumpD),
        .JumpTargetD   (JumpTargetD),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .pc            (pc),
        .StallF        (StallF),
        .InstrF        (InstrF),
        .InstrValidF   (InstrValidF),
        .FlushD        (FlushD),
        .misalign      (misalign),
        .fetch_err     (fetch_err)
    );

    always #5 CLK = ~CLK;

    // PC pipeline register the sequencer drives.
    always_ff @(posedge CLK) begin
        if (RST) pcF <= RV;
        else if (!StallF) pcF <= pc;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Instruction memory responder state.
    int mem_wait = 0;
    int lat      = 1;
    bit rand_lat = 1'b0;

    // Reference model state.
    bit          m_held, m_discard, m_mis, m_err;
    logic [31:0] m_tgt, m_instr;
    int          m_wait;

    // Expected outputs for the current cycle.
    bit          e_req, e_stallf, e_valid, e_flush, e_mis, e_err;
    logic [31:0] e_pc, e_instr;

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d %s: got %h, want %h", cyc, name, got, exp);
        end
    endtask

    // Behavioural model: one call per cycle, inputs already applied.
    task automatic model_eval(input bit rst);
        bit          redir;
        logic [31:0] raw, tgt;
        if (rst) begin
            e_req = 0; e_pc = RV; e_stallf = 1; e_instr = 32'h0;
            e_valid = 0; e_flush = 0; e_mis = 0; e_err = 0;
            m_held = 0; m_discard = 0; m_mis = 0; m_err = 0;
            m_tgt = 0; m_instr = 0; m_wait = 0;
            return;
        end
        redir = BranchTakenD || JumpD;
        raw   = BranchTakenD ? BranchTargetD : JumpTargetD;
        tgt   = raw & 32'hFFFF_FFFC;
        e_req = !m_held; e_pc = pcF; e_stallf = 1; e_instr = m_instr;
        e_valid = 0; e_flush = 0; e_mis = m_mis; e_err = m_err;
        if (m_held) begin
            e_valid = 1;
            if (redir) begin
                e_flush = 1; e_valid = 0; e_stallf = 0; e_pc = tgt; m_held = 0;
            end else if (!StallD) begin
                e_stallf = 0; e_pc = pcF + 32'd4; m_held = 0;
            end
        end else if (redir) begin
            e_flush = 1;
            if (imem_ack) begin
                e_stallf = 0; e_pc = tgt; m_discard = 0;
            end else begin
                m_tgt = tgt; m_discard = 1;
            end
        end else if (imem_ack) begin
            if (m_discard) begin
                e_stallf = 0; e_pc = m_tgt; m_discard = 0;
            end else begin
                e_instr = imem_rdata; e_valid = 1; m_instr = imem_rdata;
                if (StallD) m_held = 1;
                else begin
                    e_stallf = 0; e_pc = pcF + 32'd4;
                end
            end
        end
        if (redir && (raw % 4 != 0)) m_mis = 1;
        if (imem_ack) m_wait = 0;
        else if (e_req && m_wait < MW) m_wait++;
        if (m_wait >= MW) m_err = 1;
    endtask

    task automatic step(input bit rst, input bit stalld, input bit br, input logic [31:0] bt,
                        input bit jmp, input logic [31:0] jt);
        @(negedge CLK);
        cyc++;
        RST = rst; StallD = stalld;
        BranchTakenD = br; BranchTargetD = bt; JumpD = jmp; JumpTargetD = jt;
        imem_ack = 1'b0;
        #1;
        if (imem_req && mem_wait >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = rdata_of(imem_addr);
        end else begin
            imem_rdata = $urandom;
        end
        #1;
        model_eval(rst);
        chk("imem_req", imem_req, e_req);
        if (!rst) chk("imem_addr", imem_addr, pcF);
        chk("pc", pc, e_pc);
        chk("StallF", StallF, e_stallf);
        chk("InstrF", InstrF, e_instr);
        chk("InstrValidF", InstrValidF, e_valid);
        chk("FlushD", FlushD, e_flush);
        chk("misalign", misalign, e_mis);
        chk("fetch_err", fetch_err, e_err);
        if (rst) begin
            mem_wait = 0;
        end else if (imem_ack) begin
            mem_wait = 0;
            if (rand_lat) lat = ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 4));
        end else if (imem_req) begin
            mem_wait++;
        end
    endtask

    task automatic idle(input bit stalld);
        step(1'b0, stalld, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2:       return 32'h0040_0000 + 32'($urandom_range(0, 255) * 4);
            default: return 32'h0040_0000 + 32'($urandom_range(0, 1023));
        endcase
    endfunction

    typedef struct {
        bit          rst;
        int          lat;
        bit          req;
        logic [31:0] addr;
        logic [31:0] pc;
        bit          stallf;
        bit          valid;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        RST = 1; StallD = 0; BranchTakenD = 0; BranchTargetD = 0;
        JumpD = 0; JumpTargetD = 0; imem_ack = 0; imem_rdata = 0;

        // Reset, 1-cycle imem, then one 3-cycle-latency fetch.
        vecs[0]  = '{1, 1, 0, 32'h0,          RV,           1, 0, 32'h0};
        vecs[1]  = '{1, 1, 0, 32'h0,          RV,           1, 0, 32'h0};
        vecs[2]  = '{0, 1, 1, 32'h0040_0030, 32'h0040_0030, 1, 0, 32'h0};
        vecs[3]  = '{0, 1, 1, 32'h0040_0030, 32'h0040_0034, 0, 1, rdata_of(32'h0040_0030)};
        vecs[4]  = '{0, 1, 1, 32'h0040_0034, 32'h0040_0034, 1, 0, 32'h0};
        vecs[5]  = '{0, 1, 1, 32'h0040_0034, 32'h0040_0038, 0, 1, rdata_of(32'h0040_0034)};
        vecs[6]  = '{0, 1, 1, 32'h0040_0038, 32'h0040_0038, 1, 0, 32'h0};
        vecs[7]  = '{0, 1, 1, 32'h0040_0038, 32'h0040_003C, 0, 1, rdata_of(32'h0040_0038)};
        vecs[8]  = '{0, 3, 1, 32'h0040_003C, 32'h0040_003C, 1, 0, 32'h0};
        vecs[9]  = '{0, 3, 1, 32'h0040_003C, 32'h0040_003C, 1, 0, 32'h0};
        vecs[10] = '{0, 3, 1, 32'h0040_003C, 32'h0040_003C, 1, 0, 32'h0};
        vecs[11] = '{0, 3, 1, 32'h0040_003C, 32'h0040_0040, 0, 1, rdata_of(32'h0040_003C)};

        for (int i = 0; i < 12; i++) begin
            lat = vecs[i].lat;
            step(vecs[i].rst, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            chk("vec req", imem_req, vecs[i].req);
            if (!vecs[i].rst) chk("vec addr", imem_addr, vecs[i].addr);
            chk("vec pc", pc, vecs[i].pc);
            chk("vec StallF", StallF, vecs[i].stallf);
            chk("vec valid", InstrValidF, vecs[i].valid);
            if (vecs[i].valid) chk("vec InstrF", InstrF, vecs[i].instr);
        end

        // StallD held across the ack: HOLD, then advance when it drops.
        lat = 1;
        idle(1'b0);
        idle(1'b1);
        chk("hold ack StallF", StallF, 1'b1);
        chk("hold ack InstrF", InstrF, rdata_of(32'h0040_0040));
        idle(1'b1);
        chk("hold req", imem_req, 1'b0);
        chk("hold InstrF", InstrF, rdata_of(32'h0040_0040));
        chk("hold valid", InstrValidF, 1'b1);
        idle(1'b0);
        chk("hold release pc", pc, 32'h0040_0044);
        chk("hold release StallF", StallF, 1'b0);

        // Branch while the request is outstanding: drain, then go to the target.
        lat = 3;
        idle(1'b0);
        chk("br pre addr", imem_addr, 32'h0040_0044);
        step(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        chk("br FlushD", FlushD, 1'b1);
        idle(1'b0);
        chk("drain addr", imem_addr, 32'h0040_0044);
        chk("drain FlushD", FlushD, 1'b0);
        idle(1'b0);
        chk("drain ack valid", InstrValidF, 1'b0);
        chk("drain ack pc", pc, 32'h0040_0100);
        lat = 1;
        idle(1'b0);
        chk("br target addr", imem_addr, 32'h0040_0100);

        // Branch and jump together, coincident with the ack.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300);
        chk("br+jmp pc", pc, 32'h0000_0200);
        chk("br+jmp FlushD", FlushD, 1'b1);
        chk("br+jmp valid", InstrValidF, 1'b0);
        idle(1'b0);
        chk("br+jmp addr", imem_addr, 32'h0000_0200);

        // Misaligned target, then a request that never gets acked.
        step(1'b0, 1'b0, 1'b1, 32'h0040_0102, 1'b0, 32'h0);
        chk("misalign pc", pc, 32'h0040_0100);
        lat = 1000;
        for (int k = 1; k <= 18; k++) begin
            idle(1'b0);
            if (k == 1) chk("misalign flag", misalign, 1'b1);
            if (k == 16) chk("wait boundary err", fetch_err, 1'b0);
            if (k == 17) chk("wait expired err", fetch_err, 1'b1);
            if (k == 18) chk("timeout req", imem_req, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        lat = 0;
        idle(1'b0);
        chk("rst clr misalign", misalign, 1'b0);
        chk("rst clr fetch_err", fetch_err, 1'b0);
        chk("rst req addr", imem_addr, RV);

        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        chk("jump top pc", pc, 32'hFFFF_FFFC);
        idle(1'b0);
        chk("wrap pc", pc, 32'h0000_0000);

        // Randomised traffic against the model.
        rand_lat = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bit r, sd, b, j;
            r  = ($urandom_range(0, 299) == 0);
            sd = ($urandom_range(0, 9) < 3);
            b  = ($urandom_range(0, 9) == 0);
            j  = ($urandom_range(0, 9) == 0);
            step(r, sd, b, rand_target(), j, rand_target());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
